// File: rtl/traffic_conflict_monitor.sv
// Safety monitor between the signal controller and the lamp drivers: passes legal
// light/arrow codes through with one cycle of latency, latches a fault and flashes red otherwise.
module traffic_conflict_monitor #(
    parameter int PERSIST    = 2,
    parameter int MIN_YELLOW = 2,
    parameter int FLASH_HALF = 4,
    parameter int ALL_RED    = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [2:0] north_light_in,
    input  logic [2:0] south_light_in,
    input  logic [2:0] east_light_in,
    input  logic [2:0] west_light_in,
    input  logic       north_left_arrow_in,
    input  logic       north_right_arrow_in,
    input  logic       south_left_arrow_in,
    input  logic       south_right_arrow_in,
    input  logic       east_left_arrow_in,
    input  logic       east_right_arrow_in,
    input  logic       west_left_arrow_in,
    input  logic       west_right_arrow_in,
    input  logic       fault_clear,
    output logic [2:0] north_light,
    output logic [2:0] south_light,
    output logic [2:0] east_light,
    output logic [2:0] west_light,
    output logic       north_left_arrow,
    output logic       north_right_arrow,
    output logic       south_left_arrow,
    output logic       south_right_arrow,
    output logic       east_left_arrow,
    output logic       east_right_arrow,
    output logic       west_left_arrow,
    output logic       west_right_arrow,
    output logic       fault,
    output logic [2:0] fault_code
);

    localparam int PW   = $clog2(PERSIST + 1);
    localparam int CMAX = (FLASH_HALF > ALL_RED) ? FLASH_HALF : ALL_RED;
    localparam int CW   = $clog2(CMAX + 1);
    localparam int YW   = $clog2(MIN_YELLOW + 1);

    localparam logic [PW-1:0] PERSIST_C   = PW'(PERSIST);
    localparam logic [PW-1:0] PERS_ONE    = PW'(1);
    localparam logic [YW-1:0] MIN_Y_C     = YW'(MIN_YELLOW);
    localparam logic [YW-1:0] YEL_ONE     = YW'(1);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);
    localparam logic [CW-1:0] ALL_RED_END = CW'(ALL_RED - 1);
    localparam logic [CW-1:0] FLASH_END   = CW'(FLASH_HALF - 1);

    localparam logic [2:0] RED    = 3'b100;
    localparam logic [2:0] YELLOW = 3'b010;
    localparam logic [2:0] GREEN  = 3'b001;
    localparam logic [2:0] DARK   = 3'b000;

    typedef enum logic [1:0] {
        RECOVER = 2'd0,
        MONITOR = 2'd1,
        FAULT   = 2'd2
    } state_t;

    // Approach index: 0 north, 1 south, 2 east, 3 west; i^1 is the opposing approach.
    logic [3:0][2:0]    light_in_s;
    logic [3:0]         left_in_s, right_in_s;
    state_t             state_r, state_s;
    logic [CW-1:0]      cnt_r, cnt_s;
    logic               phase_r, phase_s;
    logic [PW-1:0]      pers_r, pers_s;
    logic [3:0][2:0]    prev_r, prev_s;
    logic [3:0][YW-1:0] yel_r, yel_s;
    logic               fault_r, fault_s;
    logic [2:0]         code_r, code_s;
    logic [3:0][2:0]    light_r, light_s;
    logic [3:0]         left_r, left_s, right_r, right_s;
    logic [6:1]         viol_s;
    logic               level_s, event_s;

    function automatic logic code_legal(input logic [2:0] c);
        case (c)
            RED, YELLOW, GREEN: return 1'b1;
            default:            return 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] first_code(input logic [6:1] v);
        logic [2:0] c;
        c = 3'd0;
        for (int k = 6; k >= 1; k--) begin
            if (v[k]) c = 3'(k);
            else      c = c;
        end
        return c;
    endfunction

    assign light_in_s = {west_light_in, east_light_in, south_light_in, north_light_in};
    assign left_in_s  = {west_left_arrow_in, east_left_arrow_in, south_left_arrow_in, north_left_arrow_in};
    assign right_in_s = {west_right_arrow_in, east_right_arrow_in, south_right_arrow_in, north_right_arrow_in};

    // Level and event violation detection on the sampled inputs.
    always_comb begin
        viol_s    = 6'b000000;
        viol_s[2] = ((light_in_s[0] != RED) || (light_in_s[1] != RED)) &&
                    ((light_in_s[2] != RED) || (light_in_s[3] != RED));
        for (int i = 0; i < 4; i++) begin
            viol_s[1] = viol_s[1] | ~code_legal(light_in_s[i]);
            viol_s[3] = viol_s[3] | ((left_in_s[i] | right_in_s[i]) & (light_in_s[i] != GREEN));
            viol_s[4] = viol_s[4] | ((prev_r[i] == GREEN) & (light_in_s[i] == RED));
            viol_s[5] = viol_s[5] | ((prev_r[i] == YELLOW) & (light_in_s[i] == RED) & (yel_r[i] < MIN_Y_C));
            viol_s[6] = viol_s[6] | (right_in_s[i] & (light_in_s[i ^ 1] != RED));
        end
    end

    assign level_s = viol_s[1] | viol_s[2] | viol_s[3] | viol_s[6];
    assign event_s = viol_s[4] | viol_s[5];

    // Next-state, history and lamp output selection.
    always_comb begin
        state_s = state_r;
        cnt_s   = cnt_r;
        phase_s = phase_r;
        pers_s  = pers_r;
        prev_s  = prev_r;
        yel_s   = yel_r;
        fault_s = fault_r;
        code_s  = code_r;
        light_s = {4{RED}};
        left_s  = 4'b0000;
        right_s = 4'b0000;
        case (state_r)
            RECOVER: begin
                if (cnt_r == ALL_RED_END) begin
                    state_s = MONITOR;
                    cnt_s   = '0;
                    prev_s  = light_in_s;
                    yel_s   = '0;
                    pers_s  = '0;
                    light_s = light_in_s;
                    left_s  = left_in_s;
                    right_s = right_in_s;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
            end
            MONITOR: begin
                if (level_s) pers_s = (pers_r == PERSIST_C) ? pers_r : pers_r + PERS_ONE;
                else         pers_s = '0;
                prev_s = light_in_s;
                for (int i = 0; i < 4; i++) begin
                    if (light_in_s[i] == YELLOW) yel_s[i] = (yel_r[i] == MIN_Y_C) ? yel_r[i] : yel_r[i] + YEL_ONE;
                    else                         yel_s[i] = '0;
                end
                if (event_s || (pers_s == PERSIST_C)) begin
                    state_s = FAULT;
                    fault_s = 1'b1;
                    code_s  = first_code(viol_s);
                    cnt_s   = '0;
                    phase_s = 1'b0;
                end else begin
                    light_s = light_in_s;
                    left_s  = left_in_s;
                    right_s = right_in_s;
                end
            end
            FAULT: begin
                if (fault_clear) begin
                    state_s = RECOVER;
                    fault_s = 1'b0;
                    code_s  = 3'd0;
                    cnt_s   = '0;
                    phase_s = 1'b0;
                end else if (cnt_r == FLASH_END) begin
                    cnt_s   = '0;
                    phase_s = ~phase_r;
                end else begin
                    cnt_s = cnt_r + CNT_ONE;
                end
                light_s = phase_s ? {4{DARK}} : {4{RED}};
            end
            default: begin
                state_s = RECOVER;
                cnt_s   = '0;
                phase_s = 1'b0;
                fault_s = 1'b0;
                code_s  = 3'd0;
            end
        endcase
    end

    // State, history and registered lamp outputs with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_r <= RECOVER;
            cnt_r   <= '0;
            phase_r <= 1'b0;
            pers_r  <= '0;
            prev_r  <= {4{RED}};
            yel_r   <= '0;
            fault_r <= 1'b0;
            code_r  <= 3'd0;
            light_r <= {4{RED}};
            left_r  <= 4'b0000;
            right_r <= 4'b0000;
        end else begin
            state_r <= state_s;
            cnt_r   <= cnt_s;
            phase_r <= phase_s;
            pers_r  <= pers_s;
            prev_r  <= prev_s;
            yel_r   <= yel_s;
            fault_r <= fault_s;
            code_r  <= code_s;
            light_r <= light_s;
            left_r  <= left_s;
            right_r <= right_s;
        end
    end

    assign north_light       = light_r[0];
    assign south_light       = light_r[1];
    assign east_light        = light_r[2];
    assign west_light        = light_r[3];
    assign north_left_arrow  = left_r[0];
    assign south_left_arrow  = left_r[1];
    assign east_left_arrow   = left_r[2];
    assign west_left_arrow   = left_r[3];
    assign north_right_arrow = right_r[0];
    assign south_right_arrow = right_r[1];
    assign east_right_arrow  = right_r[2];
    assign west_right_arrow  = right_r[3];
    assign fault             = fault_r;
    assign fault_code        = code_r;

endmodule

// File: tb/tb_traffic_conflict_monitor.sv
// Scoreboard bench for traffic_conflict_monitor: directed vectors push hand-derived
// expected lamp outputs into a queue that a separate monitor pops after every clock edge.
module tb_traffic_conflict_monitor;

    localparam int FLASH_HALF = 4;
    localparam logic [2:0] RD = 3'b100;
    localparam logic [2:0] YL = 3'b010;
    localparam logic [2:0] GN = 3'b001;
    localparam logic [2:0] BAD = 3'b011;
    localparam logic [11:0] ALLRED = 12'b100_100_100_100;
    localparam logic [11:0] DARK12 = 12'b000_000_000_000;

    typedef struct {
        logic [11:0] l;
        logic [7:0]  a;
        logic        f;
        logic [2:0]  c;
        string       name;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        fault_clear;
    logic [11:0] lin;
    logic [7:0]  ain;
    logic [11:0] lout;
    logic [7:0]  aout;
    logic        fault;
    logic [2:0]  fault_code;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    logic done     = 1'b0;

    always #5 clk = ~clk;

    traffic_conflict_monitor dut (
        .clk                  (clk),
        .reset                (reset),
        .north_light_in       (lin[2:0]),
        .south_light_in       (lin[5:3]),
        .east_light_in        (lin[8:6]),
        .west_light_in        (lin[11:9]),
        .north_left_arrow_in  (ain[0]),
        .north_right_arrow_in (ain[1]),
        .south_left_arrow_in  (ain[2]),
        .south_right_arrow_in (ain[3]),
        .east_left_arrow_in   (ain[4]),
        .east_right_arrow_in  (ain[5]),
        .west_left_arrow_in   (ain[6]),
        .west_right_arrow_in  (ain[7]),
        .fault_clear          (fault_clear),
        .north_light          (lout[2:0]),
        .south_light          (lout[5:3]),
        .east_light           (lout[8:6]),
        .west_light           (lout[11:9]),
        .north_left_arrow     (aout[0]),
        .north_right_arrow    (aout[1]),
        .south_left_arrow     (aout[2]),
        .south_right_arrow    (aout[3]),
        .east_left_arrow      (aout[4]),
        .east_right_arrow     (aout[5]),
        .west_left_arrow      (aout[6]),
        .west_right_arrow     (aout[7]),
        .fault                (fault),
        .fault_code           (fault_code)
    );

    // Monitor: one scoreboard entry is due after every active edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sbq.size() > 0) begin
            e = sbq.pop_front();
            n_checks++;
            if ({lout, aout, fault, fault_code} !== {e.l, e.a, e.f, e.c}) begin
                n_fail++;
                $display("FAIL %s: got lights=%b arrows=%b fault=%b code=%0d, required lights=%b arrows=%b fault=%b code=%0d",
                         e.name, lout, aout, fault, fault_code, e.l, e.a, e.f, e.c);
            end
        end
    end

    // Watchdog: the directed sequence must complete within a bounded time.
    initial begin
        #20000;
        if (!done) begin
            n_fail++;
            $display("FAIL timeout: expired wait for end of directed sequence");
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $finish;
        end
    end

    function automatic logic [11:0] lts(input logic [2:0] n, input logic [2:0] s,
                                        input logic [2:0] e, input logic [2:0] w);
        return {w, e, s, n};
    endfunction

    function automatic logic [11:0] nom_l(input int k);
        int p;
        p = k % 24;
        if (p < 10)      return lts(GN, GN, RD, RD);
        else if (p < 12) return lts(YL, YL, RD, RD);
        else if (p < 22) return lts(RD, RD, GN, GN);
        else             return lts(RD, RD, YL, YL);
    endfunction

    function automatic logic [7:0] nom_a(input int k);
        int p;
        p = k % 24;
        if (p < 10)                 return 8'h01;
        else if (p >= 12 && p < 22) return 8'h10;
        else                        return 8'h00;
    endfunction

    task automatic step(input logic [11:0] l, input logic [7:0] a, input logic clr, input logic rst,
                        input logic [11:0] el, input logic [7:0] ea, input logic ef,
                        input logic [2:0] ec, input string nm);
        exp_t e;
        lin = l;
        ain = a;
        fault_clear = clr;
        reset = rst;
        e.l = el;
        e.a = ea;
        e.f = ef;
        e.c = ec;
        e.name = nm;
        sbq.push_back(e);
        @(posedge clk);
        #2;
    endtask

    task automatic pass(input logic [11:0] l, input logic [7:0] a, input string nm);
        step(l, a, 1'b0, 1'b1, l, a, 1'b0, 3'd0, nm);
    endtask

    task automatic trip(input logic [11:0] l, input logic [7:0] a, input logic [2:0] c, input string nm);
        step(l, a, 1'b0, 1'b1, ALLRED, 8'h00, 1'b1, c, nm);
    endtask

    task automatic flash(input int n, input logic [11:0] l, input logic [7:0] a, input logic [2:0] c);
        for (int j = 1; j <= n; j++)
            step(l, a, 1'b0, 1'b1, (((j / FLASH_HALF) % 2) == 1) ? DARK12 : ALLRED, 8'h00, 1'b1, c, "flash");
    endtask

    task automatic recover_tail(input logic [11:0] l, input logic [7:0] a);
        for (int j = 0; j < 3; j++)
            step(l, a, 1'b0, 1'b1, ALLRED, 8'h00, 1'b0, 3'd0, "recover_red");
        pass(l, a, "recover_exit");
    endtask

    task automatic clear_recover(input logic [11:0] l, input logic [7:0] a);
        step(l, a, 1'b1, 1'b1, ALLRED, 8'h00, 1'b0, 3'd0, "clear");
        recover_tail(l, a);
    endtask

    initial begin
        reset = 1'b0;
        fault_clear = 1'b0;
        lin = ALLRED;
        ain = 8'h00;

        // Reset, then the nominal controller sequence.
        step(ALLRED, 8'h00, 1'b0, 1'b0, ALLRED, 8'h00, 1'b0, 3'd0, "reset");
        step(ALLRED, 8'h00, 1'b0, 1'b0, ALLRED, 8'h00, 1'b0, 3'd0, "reset");
        n_checks++;
        if ({lout, aout, fault, fault_code} !== {ALLRED, 8'h00, 1'b0, 3'd0}) begin
            n_fail++;
            $display("FAIL reset_state: got lights=%b arrows=%b fault=%b code=%0d",
                     lout, aout, fault, fault_code);
        end
        for (int k = 0; k < 60; k++) begin
            if (k < 3) step(nom_l(k), nom_a(k), 1'b0, 1'b1, ALLRED, 8'h00, 1'b0, 3'd0, "startup_red");
            else       pass(nom_l(k), nom_a(k), "nominal");
        end

        // Cross conflict: one cycle passes, two cycles trip with code 2.
        pass(lts(YL, YL, GN, RD), 8'h00, "conflict_single");
        pass(lts(RD, RD, GN, RD), 8'h00, "conflict_clean");
        pass(lts(GN, RD, GN, RD), 8'h01, "conflict_first");
        trip(lts(GN, RD, GN, RD), 8'h01, 3'd2, "conflict_trip");
        flash(12, lts(GN, RD, GN, RD), 8'h01, 3'd2);
        clear_recover(lts(GN, GN, RD, RD), 8'h01);

        // Green straight to red.
        trip(lts(RD, GN, RD, RD), 8'h00, 3'd4, "green_to_red");
        flash(5, lts(RD, GN, RD, RD), 8'h00, 3'd4);
        clear_recover(lts(GN, GN, RD, RD), 8'h00);

        // One-cycle yellow.
        pass(lts(YL, GN, RD, RD), 8'h00, "short_yellow");
        trip(lts(RD, GN, RD, RD), 8'h00, 3'd5, "short_yellow_trip");
        flash(3, lts(RD, GN, RD, RD), 8'h00, 3'd5);
        clear_recover(lts(GN, GN, RD, RD), 8'h00);

        // Exactly MIN_YELLOW yellow cycles is legal.
        pass(lts(YL, GN, RD, RD), 8'h00, "yellow_ok_1");
        pass(lts(YL, GN, RD, RD), 8'h00, "yellow_ok_2");
        pass(lts(RD, GN, RD, RD), 8'h00, "yellow_ok_red");
        pass(lts(RD, GN, RD, RD), 8'h00, "yellow_ok_hold");
        pass(lts(RD, YL, RD, RD), 8'h00, "south_yellow_1");
        pass(lts(RD, YL, RD, RD), 8'h00, "south_yellow_2");
        pass(ALLRED, 8'h00, "all_red");

        // Illegal code together with an arrow fault: lowest code wins.
        pass(lts(BAD, RD, RD, RD), 8'h04, "illegal_first");
        trip(lts(BAD, RD, RD, RD), 8'h04, 3'd1, "illegal_trip");
        flash(3, lts(BAD, RD, RD, RD), 8'h04, 3'd1);
        clear_recover(ALLRED, 8'h00);

        // Right arrow against a non-red opposing approach.
        pass(lts(GN, YL, RD, RD), 8'h02, "right_arrow_first");
        trip(lts(GN, YL, RD, RD), 8'h02, 3'd6, "right_arrow_trip");
        flash(2, lts(GN, YL, RD, RD), 8'h02, 3'd6);
        clear_recover(ALLRED, 8'h00);

        // fault_clear is ignored in MONITOR and loses to a trip.
        step(lts(GN, RD, GN, RD), 8'h00, 1'b1, 1'b1, lts(GN, RD, GN, RD), 8'h00, 1'b0, 3'd0, "clear_in_monitor");
        step(lts(GN, RD, GN, RD), 8'h00, 1'b1, 1'b1, ALLRED, 8'h00, 1'b1, 3'd2, "clear_with_trip");
        flash(5, lts(GN, RD, GN, RD), 8'h00, 3'd2);

        // Reset during the dark flash phase.
        step(lts(GN, RD, GN, RD), 8'h00, 1'b0, 1'b0, ALLRED, 8'h00, 1'b0, 3'd0, "reset_mid_flash");
        recover_tail(lts(GN, GN, RD, RD), 8'h01);
        pass(lts(GN, GN, RD, RD), 8'h01, "post_reset");
        pass(lts(YL, YL, RD, RD), 8'h00, "post_reset_yellow");

        @(posedge clk);
        #2;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard: %0d expected entries never checked", sbq.size());
        end
        done = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
